// File: rtl/pipeline_debug_unit.sv
// Debug/control front-end for the 5-stage CPU: owns cpu_clk (single-step or divided run with PC breakpoint)
// and drives the debug read address from debounced inc/dec buttons, registering the returned word for display.
module pipeline_debug_unit #(
  parameter logic [15:0] DEBOUNCE = 16'd50000,
  parameter logic [7:0]  RUN_DIV  = 8'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cont,
  input  logic        step,
  input  logic        inc,
  input  logic        dec,
  input  logic        mem,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
  input  logic [31:0] m_data,
  input  logic [31:0] rf_data,
  output logic        cpu_clk,
  output logic [15:0] m_rf_addr,
  output logic [31:0] disp_data,
  output logic [7:0]  addr,
  output logic [31:0] cycle_cnt,
  output logic        running,
  output logic        halted
);

  typedef enum logic [2:0] {S_STOP, S_HI, S_LO, S_RUN, S_HALT} state_t;

  // Bit order for all per-button vectors: {dec, inc, step, cont}
  logic [3:0]  w_raw;
  logic [3:0]  r_sync1, r_sync2, r_lvl, r_rise;
  logic [15:0] r_dbc [4];

  assign w_raw = {dec, inc, step, cont};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 4'b0;
      r_sync2 <= 4'b0;
      r_lvl   <= 4'b0;
      r_rise  <= 4'b0;
      for (int i = 0; i < 4; i++) r_dbc[i] <= 16'd0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 4; i++) begin
        r_rise[i] <= 1'b0;
        if (r_sync2[i] == r_lvl[i]) begin
          r_dbc[i] <= 16'd0;
        end else if (r_dbc[i] >= DEBOUNCE - 16'd1) begin
          r_lvl[i]  <= r_sync2[i];
          r_dbc[i]  <= 16'd0;
          r_rise[i] <= r_sync2[i];
        end else begin
          r_dbc[i] <= r_dbc[i] + 16'd1;
        end
      end
    end
  end

  logic w_cont_db, w_step_p, w_inc_p, w_dec_p, w_bp_hit;
  assign w_cont_db = r_lvl[0];
  assign w_step_p  = r_rise[1];
  assign w_inc_p   = r_rise[2];
  assign w_dec_p   = r_rise[3];
  assign w_bp_hit  = bp_en && (pc == bp_addr);

  state_t      r_state;
  logic [7:0]  r_div;
  logic        r_cpu_clk, r_running, r_halted;
  logic [31:0] r_cycle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_STOP;
      r_div     <= 8'd0;
      r_cpu_clk <= 1'b0;
      r_running <= 1'b0;
      r_halted  <= 1'b0;
      r_cycle   <= 32'd0;
    end else begin
      case (r_state)
        S_STOP: begin
          r_cpu_clk <= 1'b0;
          if (w_cont_db) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
            r_div     <= 8'd0;
          end else if (w_step_p) begin
            r_state   <= S_HI;
            r_cpu_clk <= 1'b1;
            r_cycle   <= r_cycle + 32'd1;
          end
        end
        S_HI: begin
          r_cpu_clk <= 1'b0;
          r_state   <= S_LO;
        end
        S_LO: r_state <= S_STOP;
        S_RUN: begin
          if (!w_cont_db) begin
            // Leaving run may cut a high phase short but never creates a rise
            r_state   <= S_STOP;
            r_running <= 1'b0;
            r_cpu_clk <= 1'b0;
            r_div     <= 8'd0;
          end else if (r_div >= RUN_DIV - 8'd1) begin
            r_div <= 8'd0;
            if (r_cpu_clk) begin
              r_cpu_clk <= 1'b0;
            end else if (w_bp_hit) begin
              r_state   <= S_HALT;
              r_running <= 1'b0;
              r_halted  <= 1'b1;
            end else begin
              r_cpu_clk <= 1'b1;
              r_cycle   <= r_cycle + 32'd1;
            end
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        S_HALT: begin
          r_cpu_clk <= 1'b0;
          if (!w_cont_db) begin
            r_state  <= S_STOP;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_STOP;
          r_cpu_clk <= 1'b0;
          r_running <= 1'b0;
          r_halted  <= 1'b0;
        end
      endcase
    end
  end

  logic [7:0]  r_addr;
  logic [7:0]  w_addr_step;
  logic [31:0] r_disp;

  always_comb begin
    w_addr_step = r_addr;
    if (w_inc_p && !w_dec_p)      w_addr_step = r_addr + 8'd1;
    else if (w_dec_p && !w_inc_p) w_addr_step = r_addr - 8'd1;
  end

  // Register-file view keeps the top bits at zero, which also clears them after a mem 1->0 change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= 8'd0;
      r_disp <= 32'd0;
    end else begin
      r_addr <= mem ? w_addr_step : {3'b000, w_addr_step[4:0]};
      r_disp <= mem ? m_data : rf_data;
    end
  end

  assign m_rf_addr = mem ? {6'b0, r_addr, 2'b00} : {11'b0, r_addr[4:0]};
  assign disp_data = r_disp;
  assign addr      = r_addr;
  assign cpu_clk   = r_cpu_clk;
  assign cycle_cnt = r_cycle;
  assign running   = r_running;
  assign halted    = r_halted;

endmodule
